mult_booth_seq: RTL and testbench



---
 rtl/mult_booth_seq.sv | 165 ++++++++++++++++
 tb/tb_mult_booth_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth_seq.sv
// ---------------------------------------------------------------------------
// mult_booth_seq
//
// Sequential signed WIDTH x WIDTH radix-4 (modified Booth) multiplier for the
// multdiv path. One operand pair is taken on a start request. The multiplier
// then retires two multiplier bits per clock, so a full product takes
// N = WIDTH/2 iterations.
//
// Optional feature macro: MULT_EARLY_ZERO_EN
//   If defined, a start with either operand equal to zero completes
//   immediately. The unit goes to DONE on the start edge and never raises busy.
//   If undefined, every operand pair takes the full N iterations.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   ctrl_mult       in   start request, sampled on the rising edge
//   operandA        in   WIDTH   multiplicand, two's complement
//   operandB        in   WIDTH   multiplier, two's complement
//   product_out     out  2*WIDTH registered signed product
//   result          out  WIDTH   low half of product_out
//   data_exception  out  registered; product does not fit in WIDTH signed bits
//   data_resultRDY  out  one-cycle completion pulse
//   busy            out  high while iterating
//   dbg_state       out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: this unit has no backpressure.
//   - A start is accepted when ctrl_mult=1 at a rising edge while the unit is
//     in IDLE or DONE.
//   - ctrl_mult is ignored while busy, and an ignored start is not queued.
//   - Each accepted start produces exactly one data_resultRDY pulse, unless
//     reset intervenes.
//   - product_out and data_exception are valid in the cycle where
//     data_resultRDY=1. They hold that value until the next completion.
// ---------------------------------------------------------------------------
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_mult,
    input  logic [WIDTH-1:0]     operandA,
    input  logic [WIDTH-1:0]     operandB,
    output logic [2*WIDTH-1:0]   product_out,
    output logic [WIDTH-1:0]     result,
    output logic                 data_exception,
    output logic                 data_resultRDY,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N) + 1;
    localparam int MW = WIDTH + 2;          // multiplicand / partial-sum width
    localparam int AW = 2 * WIDTH + 3;      // {partial sum, multiplier, b-1}

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [MW-1:0]        m_q;
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 exc_q;
    logic                 rdy_q;
    logic                 busy_q;

    logic [MW-1:0]        pp;
    logic [MW-1:0]        sum;
    logic [AW-1:0]        acc_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH:0]       top_bits;
    logic                 exc_d;
    logic                 start_zero;

`ifdef MULT_EARLY_ZERO_EN
    assign start_zero = (operandA == '0) || (operandB == '0);
`else
    assign start_zero = 1'b0;
`endif

    // One Booth iteration. The low three accumulator bits select the partial
    // product. It is added into the upper MW bits with the carry-out dropped.
    // The accumulator is then shifted arithmetically right by two.
    always_comb begin
        pp = '0;
        case (acc_q[2:0])
            3'b001, 3'b010: pp = m_q;
            3'b011:         pp = m_q << 1;
            3'b100:         pp = -(m_q << 1);
            3'b101, 3'b110: pp = -m_q;
            default:        pp = '0;
        endcase
        sum    = acc_q[AW-1 -: MW] + pp;
        acc_d  = {{2{sum[MW-1]}}, sum, acc_q[WIDTH:2]};
        prod_d = acc_d[2*WIDTH:1];
        // The product fits in WIDTH signed bits only if the upper half and the
        // sign bit of the lower half all agree.
        top_bits = prod_d[2*WIDTH-1:WIDTH-1];
        exc_d    = !((&top_bits) || !(|top_bits));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ctrl_mult) begin
                        if (start_zero) begin
                            state_q <= ST_DONE;
                            prod_q  <= '0;
                            exc_q   <= 1'b0;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                            m_q     <= {{2{operandA[WIDTH-1]}}, operandA};
                            acc_q   <= {{MW{1'b0}}, operandB, 1'b0};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= ST_DONE;
                        prod_q  <= prod_d;
                        exc_q   <= exc_d;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign product_out    = prod_q;
    assign result         = prod_q[WIDTH-1:0];
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_booth_seq
//
// Drives operand pairs into mult_booth_seq. Expected products come from plain
// 64-bit signed multiplication and are queued as each start is issued. The
// queue is popped on every completion pulse.
// ---------------------------------------------------------------------------
module tb_mult_booth_seq;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             ctrl_mult;
    logic [W-1:0]     operandA;
    logic [W-1:0]     operandB;
    logic [2*W-1:0]   product_out;
    logic [W-1:0]     result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_booth_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .operandA       (operandA),
        .operandB       (operandB),
        .product_out    (product_out),
        .result         (result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    logic           exp_exc_q[$];
    logic [2*W-1:0] last_prod = '0;
    logic           last_exc  = 1'b0;
    int unsigned    start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return pa * pb;
    endfunction

    function automatic logic ref_exc(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        logic [31:0] lo;
        p  = longint'(ref_prod(a, b));
        lo = p[31:0];
        return p != longint'($signed(lo));
    endfunction

    function automatic logic zero_fast(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_EARLY_ZERO_EN
        return (a == 0) || (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_edges(input logic [W-1:0] a, input logic [W-1:0] b);
        return zero_fast(a, b) ? 0 : 16;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2*W-1:0] ep;
        logic           ee;
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("spurious_rdy", 64'(data_resultRDY), 64'd0);
            end else begin
                ep = exp_q.pop_front();
                ee = exp_exc_q.pop_front();
                check("product", product_out, ep);
                check("result", 64'(result), 64'(ep[W-1:0]));
                check("exception", 64'(data_exception), 64'(ee));
                check("busy_at_rdy", 64'(busy), 64'd0);
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        operandA  = a;
        operandB  = b;
        ctrl_mult = 1'b1;
        if (push) begin
            exp_q.push_back(ref_prod(a, b));
            exp_exc_q.push_back(ref_exc(a, b));
        end
        @(negedge clk);
        ctrl_mult = 1'b0;
        start_cyc = cyc;
        // Scramble the inputs so that the operands must have been latched.
        operandA  = $urandom;
        operandB  = $urandom;
        if (push) check("busy_after_start", 64'(busy), 64'(!zero_fast(a, b)));
    endtask

    task automatic wait_rdy(input int exp_e, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (data_resultRDY) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
        else       check({tag, "_latency"}, 64'(cyc - start_cyc), 64'(exp_e));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        start_op(a, b, 1'b1);
        if (!zero_fast(a, b)) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            check({tag, "_held_prod"}, product_out, last_prod);
            check({tag, "_held_exc"}, 64'(data_exception), 64'(last_exc));
        end
        wait_rdy(exp_edges(a, b), tag);
        last_prod = ref_prod(a, b);
        last_exc  = ref_exc(a, b);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] specials [5];

    initial begin
        int rdy_cnt;
        logic [W-1:0] a;
        logic [W-1:0] b;

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        reset     = 1'b1;
        ctrl_mult = 1'b0;
        operandA  = '0;
        operandB  = '0;
        repeat (3) @(negedge clk);
        check("reset_product", product_out, 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(32'd7, 32'hFFFF_FFFD, "7xm3");
        check("7xm3_const", product_out, 64'hFFFF_FFFF_FFFF_FFEB);
        check("7xm3_result", 64'(result), 64'hFFFF_FFEB);
        @(negedge clk);

        do_op(32'h8000_0000, 32'h8000_0000, "min_sq");
        check("min_sq_const", product_out, 64'h4000_0000_0000_0000);
        check("min_sq_exc", 64'(data_exception), 64'd1);
        @(negedge clk);

        do_op(32'h7FFF_FFFF, 32'd2, "max_x2");
        check("max_x2_const", product_out, 64'h0000_0000_FFFF_FFFE);
        check("max_x2_exc", 64'(data_exception), 64'd1);
        @(negedge clk);

        do_op(32'h8000_0000, 32'd1, "min_x1");
        check("min_x1_const", product_out, 64'hFFFF_FFFF_8000_0000);
        check("min_x1_exc", 64'(data_exception), 64'd0);
        @(negedge clk);
        do_op(32'd3, 32'd4, "after_min");

        // A start during RUN is ignored; a start in the DONE cycle is taken.
        @(negedge clk);
        start_op(32'd5, 32'd6, 1'b1);
        repeat (3) @(negedge clk);
        operandA  = 32'd9;
        operandB  = 32'd9;
        ctrl_mult = 1'b1;
        @(negedge clk);
        ctrl_mult = 1'b0;
        wait_rdy(16, "ignored_start");
        check("ignored_start_prod", product_out, 64'd30);
        start_op(32'd9, 32'd9, 1'b1);
        wait_rdy(16, "done_start");
        check("done_start_prod", product_out, 64'd81);
        last_prod = 64'd81;
        last_exc  = 1'b0;
        @(negedge clk);

        // Reset in the middle of an operation.
        start_op(32'd123, 32'd456, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_prod", product_out, 64'd0);
        check("midrun_reset_exc", 64'(data_exception), 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_resultRDY) rdy_cnt++;
            @(negedge clk);
        end
        check("midrun_reset_no_rdy", 64'(rdy_cnt), 64'd0);
        last_prod = '0;
        last_exc  = 1'b0;

        // Zero operand.
        do_op(32'd0, 32'd12345, "zero_op");
        check("zero_op_prod", product_out, 64'd0);
        @(negedge clk);

        // Randomized operands, with some back-to-back starts in the DONE cycle.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: a = specials[$urandom_range(0, 4)];
                1: b = specials[$urandom_range(0, 4)];
                2: begin
                    a = specials[$urandom_range(0, 4)];
                    b = specials[$urandom_range(0, 4)];
                end
                default: ;
            endcase
            do_op(a, b, "rand");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
